div_ctrl: RTL and testbench

//  EX-stage front end for the 32-bit iterative divider (div). Issues DIV/DIVU
//  to it, holds the operands stable and stalls the pipeline while it runs.

---
 rtl/div_ctrl.sv | 132 +++++++++++++
 tb/tb_div_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// EX-stage front end for the iterative divider: issues DIV/DIVU, holds the
// operands stable while the divider runs, stalls the pipeline, and retires the
// {remainder, quotient} result into HI/LO. Also owns the MTHI/MTLO path and
// annuls an in-flight divide when EX is flushed.
module div_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_div_valid,
    input  logic        ex_div_signed,
    input  logic [31:0] ex_rs,
    input  logic [31:0] ex_rt,
    input  logic        flush,
    input  logic        ex_hi_we,
    input  logic [31:0] ex_hi_wdata,
    input  logic        ex_lo_we,
    input  logic [31:0] ex_lo_wdata,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        stall_req,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t     state;
    logic [3:0] drain_cnt;
    logic       retire;

    // A divide retires only from BUSY, and a same-cycle flush wins over it.
    assign retire = (state == BUSY) && !flush && div_ready_i;

    // Pipeline freeze: hold EX while a divide is issuing or running, and hold
    // a younger DIV while the controller is returning to IDLE.
    always_comb begin
        stall_req = 1'b0;
        case (state)
            IDLE:    stall_req = ex_div_valid && !flush;
            BUSY:    stall_req = !div_ready_i;
            DONE:    stall_req = ex_div_valid;
            DRAIN:   stall_req = ex_div_valid;
            default: stall_req = 1'b0;
        endcase
    end

    // Controller FSM with registered divider handshake and operand hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            drain_cnt    <= 4'd0;
            div_start_o  <= 1'b0;
            div_annul_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_op1_o    <= 32'd0;
            div_op2_o    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_div_valid && !flush) begin
                        div_signed_o <= ex_div_signed;
                        div_op1_o    <= ex_rs;
                        div_op2_o    <= ex_rt;
                        div_start_o  <= 1'b1;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        div_start_o <= 1'b0;
                        div_annul_o <= 1'b1;
                        drain_cnt   <= 4'd0;
                        state       <= DRAIN;
                    end else if (div_ready_i) begin
                        div_start_o <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // One cycle with start low lets the divider leave DivEnd.
                    state <= IDLE;
                end
                DRAIN: begin
                    // Annul held long enough for the divider to return to idle.
                    if (drain_cnt == DRAIN_LAST) begin
                        div_annul_o <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // HI register: divider retirement first, then MTHI.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_o <= 32'd0;
        end else if (retire) begin
            hi_o <= div_result_i[63:32];
        end else if (ex_hi_we && !flush) begin
            hi_o <= ex_hi_wdata;
        end
    end

    // LO register: divider retirement first, then MTLO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lo_o <= 32'd0;
        end else if (retire) begin
            lo_o <= div_result_i[31:0];
        end else if (ex_lo_we && !flush) begin
            lo_o <= ex_lo_wdata;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural 32-iteration divider attached.
module tb_div_ctrl;

    logic        clk;
    logic        resetn;
    logic        ex_div_valid;
    logic        ex_div_signed;
    logic [31:0] ex_rs;
    logic [31:0] ex_rt;
    logic        flush;
    logic        ex_hi_we;
    logic [31:0] ex_hi_wdata;
    logic        ex_lo_we;
    logic [31:0] ex_lo_wdata;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic        stall_req;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_vec = 0;
    int n_bad = 0;

    div_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ex_div_valid (ex_div_valid),
        .ex_div_signed(ex_div_signed),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .flush        (flush),
        .ex_hi_we     (ex_hi_we),
        .ex_hi_wdata  (ex_hi_wdata),
        .ex_lo_we     (ex_lo_we),
        .ex_lo_wdata  (ex_lo_wdata),
        .div_ready_i  (div_ready_i),
        .div_result_i (div_result_i),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .stall_req    (stall_req),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divider: Free -> On (33 cycles) or ByZero (1 cycle) -> End.
    typedef enum logic [1:0] {DV_FREE, DV_BYZ, DV_ON, DV_END} dv_t;
    dv_t         dv_st;
    int          dv_cnt;
    logic [63:0] dv_res;
    logic        force_rdy;
    logic [63:0] force_res;

    function automatic logic [63:0] divide(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dv_st  <= DV_FREE;
            dv_cnt <= 0;
            dv_res <= 64'd0;
        end else begin
            case (dv_st)
                DV_FREE: if (div_start_o && !div_annul_o) begin
                    if (div_op2_o == 32'd0) begin
                        dv_res <= 64'd0;
                        dv_st  <= DV_BYZ;
                    end else begin
                        dv_res <= divide(div_signed_o, div_op1_o, div_op2_o);
                        dv_cnt <= 0;
                        dv_st  <= DV_ON;
                    end
                end
                DV_BYZ: dv_st <= DV_END;
                DV_ON: begin
                    if (div_annul_o) dv_st <= DV_FREE;
                    else if (dv_cnt == 32) dv_st <= DV_END;
                    else dv_cnt <= dv_cnt + 1;
                end
                DV_END: if (!div_start_o) dv_st <= DV_FREE;
                default: dv_st <= DV_FREE;
            endcase
        end
    end

    assign div_ready_i  = (dv_st == DV_END) || force_rdy;
    assign div_result_i = force_rdy ? force_res : dv_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one DIV in EX (called just after a negedge) and hold it until
    // stall_req drops; cyc counts EX cycles including the releasing cycle.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic st_last);
        logic s;
        ex_div_valid  = 1'b1;
        ex_div_signed = sgn;
        ex_rs         = a;
        ex_rt         = b;
        cyc = 0;
        s   = 1'b1;
        st_last = 1'b0;
        while (s && cyc < 200) begin
            cyc++;
            #1;
            s       = stall_req;
            st_last = div_start_o;
            @(negedge clk);
        end
        ex_div_valid = 1'b0;
        if (s) chk("div_timeout", 64'(cyc), 64'd0);
    endtask

    int   cyc;
    int   cyc2;
    logic stl;

    initial begin
        resetn = 1'b0; ex_div_valid = 1'b0; ex_div_signed = 1'b0;
        ex_rs = 32'd0; ex_rt = 32'd0; flush = 1'b0;
        ex_hi_we = 1'b0; ex_hi_wdata = 32'd0; ex_lo_we = 1'b0; ex_lo_wdata = 32'd0;
        force_rdy = 1'b0; force_res = 64'd0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", {61'd0, div_start_o, div_annul_o, div_signed_o}, 64'd0);
        chk("reset_ops", {div_op1_o, div_op2_o}, 64'd0);
        chk("reset_hilo", {hi_o, lo_o}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // 1: DIVU 100/7
        do_div(1'b0, 32'd100, 32'd7, cyc, stl);
        chk("t1_cycles", 64'(cyc), 64'd36);
        chk("t1_start_at_ready", 64'(stl), 64'd1);
        chk("t1_start_in_done", 64'(div_start_o), 64'd0);
        chk("t1_hi", 64'(hi_o), 64'd2);
        chk("t1_lo", 64'(lo_o), 64'd14);
        @(negedge clk);

        // 2: DIV and DIVU of 0xFFFFFFF9 by 2
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, cyc, stl);
        chk("t2s_lo", 64'(lo_o), 64'h0000_0000_FFFF_FFFD);
        chk("t2s_hi", 64'(hi_o), 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        do_div(1'b0, 32'hFFFF_FFF9, 32'd2, cyc, stl);
        chk("t2u_lo", 64'(lo_o), 64'h0000_0000_7FFF_FFFC);
        chk("t2u_hi", 64'(hi_o), 64'd1);
        @(negedge clk);

        // 3: divide by zero, then a normal divide
        do_div(1'b0, 32'd5, 32'd0, cyc, stl);
        chk("t3_cycles", 64'(cyc), 64'd4);
        chk("t3_hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        do_div(1'b0, 32'd9, 32'd3, cyc, stl);
        chk("t3b_cycles", 64'(cyc), 64'd36);
        chk("t3b_hilo", {hi_o, lo_o}, {32'd0, 32'd3});
        @(negedge clk);

        // 4: flush on the 10th BUSY cycle
        ex_hi_we = 1'b1; ex_hi_wdata = 32'hAAAA_0001;
        @(negedge clk);
        ex_hi_we = 1'b0;
        ex_div_valid = 1'b1; ex_div_signed = 1'b0; ex_rs = 32'd100; ex_rt = 32'd7;
        repeat (10) @(negedge clk);
        chk("t4_busy_start", 64'(div_start_o), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; ex_div_valid = 1'b0;
        force_rdy = 1'b1; force_res = 64'hDEAD_BEEF_0BAD_F00D;
        chk("t4_drain1", {62'd0, div_annul_o, div_start_o}, 64'd2);
        @(negedge clk);
        chk("t4_drain2", {62'd0, div_annul_o, div_start_o}, 64'd2);
        @(negedge clk);
        chk("t4_exit_annul", 64'(div_annul_o), 64'd0);
        @(negedge clk);
        force_rdy = 1'b0;
        chk("t4_hilo_kept", {hi_o, lo_o}, {32'hAAAA_0001, 32'd3});
        @(negedge clk);

        // 5: back-to-back DIVU 8/3 then 7/2
        do_div(1'b0, 32'd8, 32'd3, cyc, stl);
        chk("t5a_hilo", {hi_o, lo_o}, {32'd2, 32'd2});
        do_div(1'b0, 32'd7, 32'd2, cyc2, stl);
        chk("t5a_cycles", 64'(cyc), 64'd36);
        chk("t5b_cycles", 64'(cyc2), 64'd37);
        chk("t5b_hilo", {hi_o, lo_o}, {32'd1, 32'd3});
        @(negedge clk);

        // 6: MTHI/MTLO with and without flush, then reset mid-divide
        ex_hi_we = 1'b1; ex_hi_wdata = 32'h1234;
        @(negedge clk);
        ex_hi_we = 1'b0;
        chk("t6_mthi", 64'(hi_o), 64'h1234);
        ex_hi_we = 1'b1; ex_hi_wdata = 32'h5678; ex_lo_we = 1'b1; ex_lo_wdata = 32'h9999; flush = 1'b1;
        @(negedge clk);
        ex_hi_we = 1'b0; ex_lo_we = 1'b0; flush = 1'b0;
        chk("t6_flushed_we", {hi_o, lo_o}, {32'h1234, 32'd3});
        ex_lo_we = 1'b1; ex_lo_wdata = 32'h4321;
        @(negedge clk);
        ex_lo_we = 1'b0;
        chk("t6_mtlo", 64'(lo_o), 64'h4321);
        ex_div_valid = 1'b1; ex_div_signed = 1'b1; ex_rs = 32'd50; ex_rt = 32'd3;
        repeat (5) @(negedge clk);
        ex_div_valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk("t6_rst_ctl", {60'd0, div_start_o, div_annul_o, div_signed_o, stall_req}, 64'd0);
        chk("t6_rst_ops", {div_op1_o, div_op2_o}, 64'd0);
        chk("t6_rst_hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
